// File: rtl/opcode_buffer_pkg.sv
// -----------------------------------------------------------------------------
// opcode_buffer_pkg
// Shared definitions for the opcode prefetch queue and its storage FIFO:
//   - fetchState_t : fetch sequencer state encoding (IDLE / FETCH)
//   - BYTE_WIDTH   : width of one memory transfer
//   - bytesPerWord : number of byte transfers that make up one opcode word
//   - byteIdxWidth : width of the byte-within-word counter
//   - ptrWidth     : width of a FIFO read/write pointer
//   - countWidth   : width of an occupancy counter able to hold 0..depth
// No ports (package).
// -----------------------------------------------------------------------------
package opcode_buffer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetchState_t;

    localparam int BYTE_WIDTH = 8;

    function automatic int bytesPerWord(input int wordWidth);
        return wordWidth / BYTE_WIDTH;
    endfunction

    // Keep the counter at least one bit wide even for single-byte words.
    function automatic int byteIdxWidth(input int wordWidth);
        return (wordWidth / BYTE_WIDTH > 1) ? $clog2(wordWidth / BYTE_WIDTH) : 1;
    endfunction

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int countWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/opcode_fifo.sv
// -----------------------------------------------------------------------------
// opcode_fifo
// DEPTH-entry register FIFO holding {opcode word, opcode address} pairs.
// The head entry, the valid flag and the occupancy count are all registered,
// so consumers see stable values for the whole cycle.
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset (empties the FIFO)
//   flush      in   synchronous empty, same effect as reset, beats push/pop
//   push       in   write pushData at the tail
//   pushData   in   entry to write
//   pop        in   drop the head entry (ignored while empty)
//   headData   out  registered head entry (cleared by reset/flush)
//   headValid  out  registered "FIFO is non-empty"
//   count      out  registered number of occupied entries
// -----------------------------------------------------------------------------
module opcode_fifo
    import opcode_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         pushData,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         headData,
    output logic                          headValid,
    output logic [countWidth(DEPTH)-1:0]  count
);

    localparam int PW = ptrWidth(DEPTH);
    localparam int CW = countWidth(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rdPtr;
    logic [PW-1:0]         wrPtr;
    logic [PW-1:0]         rdPtrNext;
    logic [CW-1:0]         countNext;
    logic                  popEff;
    logic                  pushEff;

    // A pop on an empty FIFO is dropped; a push into a full FIFO is only
    // accepted when the same edge frees a slot.
    assign popEff    = pop && (count != '0);
    assign pushEff   = push && ((count != CW'(DEPTH)) || popEff);
    assign rdPtrNext = rdPtr + PW'(1);
    assign countNext = count + CW'(pushEff) - CW'(popEff);

    // NOTE: the storage array has no reset; its contents are never observed
    // until written, and leaving it out keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (pushEff) begin
            mem[wrPtr] <= pushData;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            headValid <= 1'b0;
            headData  <= '0;
        end else begin
            if (pushEff) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (popEff) begin
                rdPtr <= rdPtrNext;
            end
            count     <= countNext;
            headValid <= (countNext != '0);

            // Head only moves on a pop, or on a push into an empty FIFO.
            // When popping the last stored entry while pushing, the new
            // entry has not reached mem yet, so forward it directly.
            if (popEff) begin
                if (count > CW'(1)) begin
                    headData <= mem[rdPtrNext];
                end else if (pushEff) begin
                    headData <= pushData;
                end
            end else if (pushEff && (count == '0)) begin
                headData <= pushData;
            end
        end
    end

endmodule

// File: rtl/opcode_prefetch_queue.sv
// -----------------------------------------------------------------------------
// opcode_prefetch_queue
// Fetches opcode words byte-by-byte from a byte-wide memory and queues them,
// together with the address of each word's first byte, for a consumer.
// Ports:
//   clk          in   sole clock
//   reset        in   synchronous active-high reset, overrides everything
//   fetchEnable  in   permits starting new word fetches
//   redirect     in   flush queue and partial word, restart at redirectIp
//   redirectIp   in   new fetch address
//   ramData      in   byte returned by memory for ramAddress
//   ramBusy      in   memory stall; a byte transfers only when low
//   ramRequest   out  registered byte request
//   ramAddress   out  registered byte address (the fetch pointer)
//   opcodeTake   in   consumer pops the head entry
//   opcodeValid  out  queue is non-empty
//   opcode       out  head entry word
//   opcodeIp     out  address of the head word's first byte
//   count        out  number of occupied entries
//   busy         out  same as ramRequest
// -----------------------------------------------------------------------------
module opcode_prefetch_queue
    import opcode_buffer_pkg::*;
#(
    parameter int                      ADDRESS_WIDTH = 32,
    parameter int                      WORD_WIDTH    = 32,
    parameter int                      DEPTH         = 4,
    parameter bit                      BIG_ENDIAN    = 1'b0,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_IP     = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetchEnable,
    input  logic                          redirect,
    input  logic [ADDRESS_WIDTH-1:0]      redirectIp,
    input  logic [7:0]                    ramData,
    input  logic                          ramBusy,
    output logic                          ramRequest,
    output logic [ADDRESS_WIDTH-1:0]      ramAddress,
    input  logic                          opcodeTake,
    output logic                          opcodeValid,
    output logic [WORD_WIDTH-1:0]         opcode,
    output logic [ADDRESS_WIDTH-1:0]      opcodeIp,
    output logic [countWidth(DEPTH)-1:0]  count,
    output logic                          busy
);

    localparam int BPW = bytesPerWord(WORD_WIDTH);
    localparam int BCW = byteIdxWidth(WORD_WIDTH);
    localparam int CW  = countWidth(DEPTH);

    fetchState_t              state;
    fetchState_t              stateNext;
    logic [ADDRESS_WIDTH-1:0] fetchPtr;
    logic [ADDRESS_WIDTH-1:0] wordIp;
    logic [ADDRESS_WIDTH-1:0] pushIp;
    logic [BCW-1:0]           byteIndex;
    logic [BCW-1:0]           laneSel;
    logic [WORD_WIDTH-1:0]    wordBuf;
    logic [WORD_WIDTH-1:0]    mergedWord;
    logic [CW:0]              occupancy;
    logic                     byteAccept;
    logic                     lastByte;
    logic                     pushNow;
    logic                     slotFree;

    assign ramRequest = (state == FETCH);
    assign busy       = ramRequest;
    assign ramAddress = fetchPtr;

    assign byteAccept = ramRequest && !ramBusy;
    assign lastByte   = (byteIndex == BCW'(BPW - 1));
    assign pushNow    = byteAccept && lastByte && !redirect;

    // The word's start address is latched with its first byte; for
    // single-byte words the first byte is also the last, so take it live.
    assign pushIp = (byteIndex == '0) ? fetchPtr : wordIp;

    // A new word may start only if the queue will still have a free slot
    // after any push happening on this same edge.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pushNow};
    assign slotFree  = (occupancy < (CW + 1)'(DEPTH));

    assign laneSel = BIG_ENDIAN ? (BCW'(BPW - 1) - byteIndex) : byteIndex;

    // NOTE: combinational blocks assign a default to every output first so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        mergedWord = wordBuf;
        for (int b = 0; b < BPW; b++) begin
            if (laneSel == BCW'(b)) begin
                mergedWord[b*BYTE_WIDTH +: BYTE_WIDTH] = ramData;
            end
        end
    end

    always_comb begin
        stateNext = state;
        if (redirect) begin
            stateNext = fetchEnable ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fetchEnable && slotFree) begin
                        stateNext = FETCH;
                    end
                end
                FETCH: begin
                    // Only leave at a word boundary, so a started word
                    // always completes.
                    if (byteAccept && lastByte && !(fetchEnable && slotFree)) begin
                        stateNext = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPtr  <= RESET_IP;
            wordIp    <= RESET_IP;
            byteIndex <= '0;
            wordBuf   <= '0;
        end else if (redirect) begin
            // Any byte accepted on this edge belongs to the abandoned stream.
            fetchPtr  <= redirectIp;
            byteIndex <= '0;
            wordBuf   <= '0;
        end else if (byteAccept) begin
            fetchPtr <= fetchPtr + ADDRESS_WIDTH'(1);
            wordBuf  <= mergedWord;
            if (byteIndex == '0) begin
                wordIp <= fetchPtr;
            end
            byteIndex <= lastByte ? '0 : byteIndex + BCW'(1);
        end
    end

    opcode_fifo #(
        .DATA_WIDTH (WORD_WIDTH + ADDRESS_WIDTH),
        .DEPTH      (DEPTH)
    ) fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (pushNow),
        .pushData  ({mergedWord, pushIp}),
        .pop       (opcodeTake && !redirect),
        .headData  ({opcode, opcodeIp}),
        .headValid (opcodeValid),
        .count     (count)
    );

endmodule

// File: tb/tb_opcode_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_opcode_prefetch_queue
// Directed bench. Memory returns the low address byte as data. Instance dut
// uses default parameters; dut2 is big-endian starting near the top of the
// address space to exercise address wrap inside a word.
// -----------------------------------------------------------------------------
module tb_opcode_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        fetchEnable;
    logic        redirect;
    logic [31:0] redirectIp;
    logic [7:0]  ramData;
    logic        ramBusy;
    logic        ramRequest;
    logic [31:0] ramAddress;
    logic        opcodeTake;
    logic        opcodeValid;
    logic [31:0] opcode;
    logic [31:0] opcodeIp;
    logic [2:0]  count;
    logic        busy;

    logic        reset2;
    logic        fetchEnable2;
    logic        redirect2;
    logic [31:0] redirectIp2;
    logic [7:0]  ramData2;
    logic        ramBusy2;
    logic        ramRequest2;
    logic [31:0] ramAddress2;
    logic        opcodeTake2;
    logic        opcodeValid2;
    logic [31:0] opcode2;
    logic [31:0] opcodeIp2;
    logic [2:0]  count2;
    logic        busy2;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    assign ramData  = ramAddress[7:0];
    assign ramData2 = ramAddress2[7:0];

    opcode_prefetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .fetchEnable (fetchEnable),
        .redirect    (redirect),
        .redirectIp  (redirectIp),
        .ramData     (ramData),
        .ramBusy     (ramBusy),
        .ramRequest  (ramRequest),
        .ramAddress  (ramAddress),
        .opcodeTake  (opcodeTake),
        .opcodeValid (opcodeValid),
        .opcode      (opcode),
        .opcodeIp    (opcodeIp),
        .count       (count),
        .busy        (busy)
    );

    opcode_prefetch_queue #(
        .BIG_ENDIAN (1'b1),
        .RESET_IP   (32'hFFFF_FFFE)
    ) dut2 (
        .clk         (clk),
        .reset       (reset2),
        .fetchEnable (fetchEnable2),
        .redirect    (redirect2),
        .redirectIp  (redirectIp2),
        .ramData     (ramData2),
        .ramBusy     (ramBusy2),
        .ramRequest  (ramRequest2),
        .ramAddress  (ramAddress2),
        .opcodeTake  (opcodeTake2),
        .opcodeValid (opcodeValid2),
        .opcode      (opcode2),
        .opcodeIp    (opcodeIp2),
        .count       (count2),
        .busy        (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        fetchEnable  = 1'b1;
        redirect     = 1'b0;
        redirectIp   = '0;
        ramBusy      = 1'b0;
        opcodeTake   = 1'b0;
        reset2       = 1'b1;
        fetchEnable2 = 1'b1;
        redirect2    = 1'b0;
        redirectIp2  = '0;
        ramBusy2     = 1'b0;
        opcodeTake2  = 1'b0;

        // Reset state
        step();
        check("rst_ramRequest", 64'(ramRequest), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ramAddress", 64'(ramAddress), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_opcodeValid", 64'(opcodeValid), 64'd0);
        check("rst_opcode", 64'(opcode), 64'd0);
        check("rst_opcodeIp", 64'(opcodeIp), 64'd0);
        check("rst2_ramAddress", 64'(ramAddress2), 64'hFFFF_FFFE);
        check("rst2_ramRequest", 64'(ramRequest2), 64'd0);

        // First word after reset release
        reset = 1'b0;
        step();
        check("start_ramRequest", 64'(ramRequest), 64'd1);
        check("start_busy", 64'(busy), 64'd1);
        check("start_ramAddress", 64'(ramAddress), 64'd0);
        check("start_opcodeValid", 64'(opcodeValid), 64'd0);
        step(); step(); step();
        check("w0_pre_ramAddress", 64'(ramAddress), 64'd3);
        check("w0_pre_opcodeValid", 64'(opcodeValid), 64'd0);
        step();
        check("w0_opcodeValid", 64'(opcodeValid), 64'd1);
        check("w0_opcode", 64'(opcode), 64'h0302_0100);
        check("w0_opcodeIp", 64'(opcodeIp), 64'd0);
        check("w0_count", 64'(count), 64'd1);
        check("w0_noBubble", 64'(ramRequest), 64'd1);
        check("w0_ramAddress", 64'(ramAddress), 64'd4);

        // Fill to DEPTH without pops
        repeat (11) step();
        check("fill_count3", 64'(count), 64'd3);
        check("fill_ramRequest", 64'(ramRequest), 64'd1);
        check("fill_ramAddress", 64'(ramAddress), 64'h0F);
        step();
        check("full_count", 64'(count), 64'd4);
        check("full_ramRequest", 64'(ramRequest), 64'd0);
        check("full_ramAddress", 64'(ramAddress), 64'h10);
        check("full_headStable", 64'(opcode), 64'h0302_0100);
        step(); step();
        check("full_idle_ramRequest", 64'(ramRequest), 64'd0);
        check("full_idle_count", 64'(count), 64'd4);

        // One pop frees a slot, fetch resumes at 0x10
        opcodeTake = 1'b1;
        step();
        opcodeTake = 1'b0;
        check("pop_count", 64'(count), 64'd3);
        check("pop_opcode", 64'(opcode), 64'h0706_0504);
        check("pop_opcodeIp", 64'(opcodeIp), 64'd4);
        check("pop_ramRequest", 64'(ramRequest), 64'd0);
        step();
        check("resume_ramRequest", 64'(ramRequest), 64'd1);
        check("resume_ramAddress", 64'(ramAddress), 64'h10);
        step();
        check("resume_byte0", 64'(ramAddress), 64'h11);

        // Redirect mid-word together with a pop
        redirect   = 1'b1;
        redirectIp = 32'h100;
        opcodeTake = 1'b1;
        step();
        redirect   = 1'b0;
        opcodeTake = 1'b0;
        check("redir_count", 64'(count), 64'd0);
        check("redir_opcodeValid", 64'(opcodeValid), 64'd0);
        check("redir_ramRequest", 64'(ramRequest), 64'd1);
        check("redir_ramAddress", 64'(ramAddress), 64'h100);
        step(); step();
        check("redir_byte1_ramAddress", 64'(ramAddress), 64'h102);

        // Memory stall on byte 2 for three edges
        ramBusy = 1'b1;
        repeat (3) begin
            step();
            check("stall_ramAddress", 64'(ramAddress), 64'h102);
            check("stall_ramRequest", 64'(ramRequest), 64'd1);
        end
        ramBusy = 1'b0;
        step();
        check("stall_byte2_ramAddress", 64'(ramAddress), 64'h103);
        check("stall_byte2_opcodeValid", 64'(opcodeValid), 64'd0);
        step();
        check("redir_w_opcodeValid", 64'(opcodeValid), 64'd1);
        check("redir_w_opcode", 64'(opcode), 64'h0302_0100);
        check("redir_w_opcodeIp", 64'(opcodeIp), 64'h100);
        check("redir_w_count", 64'(count), 64'd1);

        // fetchEnable falls mid-word: word completes, then idle
        step();
        fetchEnable = 1'b0;
        step(); step();
        check("fe_low_midword_ramRequest", 64'(ramRequest), 64'd1);
        check("fe_low_midword_ramAddress", 64'(ramAddress), 64'h107);
        step();
        check("fe_low_done_count", 64'(count), 64'd2);
        check("fe_low_done_ramRequest", 64'(ramRequest), 64'd0);
        check("fe_low_done_ramAddress", 64'(ramAddress), 64'h108);
        step();
        check("fe_low_idle", 64'(ramRequest), 64'd0);

        // Simultaneous push and pop
        fetchEnable = 1'b1;
        step();
        check("fe_high_ramRequest", 64'(ramRequest), 64'd1);
        check("fe_high_ramAddress", 64'(ramAddress), 64'h108);
        step(); step(); step();
        opcodeTake = 1'b1;
        step();
        opcodeTake = 1'b0;
        check("pushpop_count", 64'(count), 64'd2);
        check("pushpop_opcode", 64'(opcode), 64'h0706_0504);
        check("pushpop_opcodeIp", 64'(opcodeIp), 64'h104);
        check("pushpop_ramRequest", 64'(ramRequest), 64'd1);
        check("pushpop_ramAddress", 64'(ramAddress), 64'h10C);

        // Reset mid-word with count=2, asserted together with redirect
        step();
        reset      = 1'b1;
        redirect   = 1'b1;
        redirectIp = 32'h200;
        step();
        check("midrst_ramRequest", 64'(ramRequest), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ramAddress", 64'(ramAddress), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_opcodeValid", 64'(opcodeValid), 64'd0);
        check("midrst_opcode", 64'(opcode), 64'd0);
        check("midrst_opcodeIp", 64'(opcodeIp), 64'd0);
        reset    = 1'b0;
        redirect = 1'b0;
        step();
        check("restart_ramRequest", 64'(ramRequest), 64'd1);
        check("restart_ramAddress", 64'(ramAddress), 64'd0);

        // Pop on empty queue is ignored
        opcodeTake = 1'b1;
        step();
        opcodeTake = 1'b0;
        check("emptypop_count", 64'(count), 64'd0);
        check("emptypop_opcodeValid", 64'(opcodeValid), 64'd0);
        check("emptypop_ramAddress", 64'(ramAddress), 64'd1);

        // Big-endian instance with address wrap inside the word
        reset2 = 1'b0;
        step();
        check("be_ramRequest", 64'(ramRequest2), 64'd1);
        check("be_ramAddress", 64'(ramAddress2), 64'hFFFF_FFFE);
        step(); step();
        check("be_wrap_ramAddress", 64'(ramAddress2), 64'd0);
        step(); step();
        check("be_opcodeValid", 64'(opcodeValid2), 64'd1);
        check("be_opcode", 64'(opcode2), 64'hFEFF_0001);
        check("be_opcodeIp", 64'(opcodeIp2), 64'hFFFF_FFFE);
        check("be_ramAddress_after", 64'(ramAddress2), 64'd2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/opcode_prefetch_queue.md
OPCODE_PREFETCH_QUEUE -- requirements
Module: opcode_prefetch_queue

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: width of all addresses.
REQ-002 Parameter WORD_WIDTH, default 32: opcode width, a multiple of 8, at least 8.
REQ-003 Parameter DEPTH, default 4: queue entries, a power of two, at least 2.
REQ-004 Parameter BIG_ENDIAN, default 0: 0 = byte at lowest address in opcode[7:0]; 1 = in the top byte.
REQ-005 Parameter RESET_IP, default 0: fetch address after reset.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 fetchEnable  in  1  permits starting new word fetches.
REQ-009 redirect  in  1  flush the queue and restart fetching at redirectIp.
REQ-010 redirectIp  in  ADDRESS_WIDTH  new fetch address.
REQ-011 ramData  in  8  byte returned by memory.
REQ-012 ramBusy  in  1  memory stall; a byte transfers only when low.
REQ-013 ramRequest  out  1  registered byte request.
REQ-014 ramAddress  out  ADDRESS_WIDTH  registered byte address.
REQ-015 opcodeTake  in  1  consumer pops the head entry.
REQ-016 opcodeValid  out  1  queue is non-empty.
REQ-017 opcode  out  WORD_WIDTH  head entry word.
REQ-018 opcodeIp  out  ADDRESS_WIDTH  address of the head word's first byte.
REQ-019 count  out  clog2(DEPTH+1)  number of occupied entries.
REQ-020 busy  out  1  equals ramRequest; a word fetch is in progress.

Function
REQ-021 States: IDLE and FETCH. IDLE->FETCH on an edge with fetchEnable=1 and count+pendingPush<DEPTH. FETCH->IDLE after a word's last byte when fetchEnable=0 or no slot is free.
REQ-022 Byte transfer: a byte is accepted on an edge with ramRequest=1 and ramBusy=0. On that edge ramData is sampled and ramAddress increments by 1 (mod 2^ADDRESS_WIDTH).
REQ-023 A byte counter runs 0..WORD_WIDTH/8-1 and places each byte per BIG_ENDIAN.
REQ-024 The edge accepting the last byte pushes {word, startAddress}; opcodeValid can rise the next cycle.
REQ-025 With ramBusy=0 and a free slot, ramRequest stays high across word boundaries with no bubble.
REQ-026 fetchEnable falling mid-word: the current word completes, then IDLE.
REQ-027 No new word starts unless a slot is free, so a push never overflows.
REQ-028 opcodeTake with count=0 is ignored. Simultaneous push and pop leaves count unchanged.
REQ-029 redirect has priority over push, pop and fetchEnable. On that edge: queue emptied, count=0, partial word and any byte accepted that edge discarded, fetch pointer=redirectIp.
REQ-030 After redirect, if fetchEnable=1 the next cycle shows ramRequest=1 with ramAddress=redirectIp; otherwise IDLE.
REQ-031 The queue head outputs (opcode, opcodeIp) change only on a push into an empty queue, a pop, or redirect/reset.
REQ-032 The fetch address wraps from 2^ADDRESS_WIDTH-1 to 0, also inside a word.

Reset
REQ-033 reset=1 at an edge forces: IDLE, ramRequest=0, busy=0, ramAddress=RESET_IP, fetch pointer=RESET_IP, count=0, opcodeValid=0, opcode=0, opcodeIp=0. Any in-flight fetch is abandoned.
REQ-034 reset overrides redirect and every other input.

Structure
REQ-035 Shared package opcode_buffer_pkg holds the state encoding and the bytes-per-word and pointer-width helper constants.
REQ-036 Storage is one sub-module, opcode_fifo: a DEPTH x (WORD_WIDTH+ADDRESS_WIDTH) register FIFO with push, pop, flush, count and head outputs. All outputs are registered.

Verification
(Memory model: byte at address a = a[7:0]; default parameters.)
REQ-037 Reset release with fetchEnable=1 and ramBusy=0 -> ramRequest=1 one cycle later; opcodeValid=1 five cycles after the first enabled edge; opcode=0x03020100, opcodeIp=0.
REQ-038 No pops -> queue fills to count=4 (words 0x03020100..0x0F0E0D0C), then ramRequest=0. One pop -> the fetch at ramAddress=0x10 resumes.
REQ-039 ramBusy=1 for 3 cycles during byte 2 -> that byte is held; final word still 0x03020100; completion is 3 cycles later.
REQ-040 redirect with redirectIp=0x100 mid-word, at the same edge as opcodeTake -> count=0; next cycle ramAddress=0x100; next opcode=0x03020100 with opcodeIp=0x100.
REQ-041 BIG_ENDIAN=1 with RESET_IP=0xFFFFFFFE -> opcode=0xFEFF0001; ramAddress wraps to 0.
REQ-042 reset asserted mid-word with count=2 -> all outputs at reset values on the next cycle; fetching restarts at RESET_IP.
